// File: rtl/reg_file_pkg.sv
// Shared sizing defaults and sweep FSM state encoding for the register file.
package reg_file_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: read ports, write-back, flag update and clear-sweep handshake.
interface reg_file_if
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
    parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W
);

    logic [ADDR_W-1:0] RdAddrA;
    logic [ADDR_W-1:0] RdAddrB;
    logic [DATA_W-1:0] RdDataA;
    logic [DATA_W-1:0] RdDataB;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;
    logic              WrEn;
    logic              FlagEn;
    logic              ZeroIn;
    logic              CarryIn;
    logic              ZeroFlag;
    logic              CarryFlag;
    logic              Clear;
    logic              Busy;

    modport master (
        output RdAddrA, RdAddrB, WrAddr, WrData, WrEn,
        output FlagEn, ZeroIn, CarryIn, Clear,
        input  RdDataA, RdDataB, ZeroFlag, CarryFlag, Busy
    );

    modport slave (
        input  RdAddrA, RdAddrB, WrAddr, WrData, WrEn,
        input  FlagEn, ZeroIn, CarryIn, Clear,
        output RdDataA, RdDataB, ZeroFlag, CarryFlag, Busy
    );

endinterface

// File: rtl/reg_file_clear_sequencer.sv
// Clear-sweep FSM: walks an address counter over every register, one per cycle,
// raising Busy for exactly NUM_REGS cycles after a Clear request.
module clear_sequencer
    import reg_file_pkg::*;
#(
    parameter int unsigned ADDR_W   = reg_file_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = reg_file_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Clear,
    output logic              Busy,
    output logic              SweepEn,
    output logic [ADDR_W-1:0] SweepAddr,
    output logic              FlagClr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    sweep_state_t      state;
    sweep_state_t      state_next;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            if (Clear) begin
                cnt <= '0;
            end
        end else begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Clear) state_next = SWEEP;
            SWEEP:   if (cnt == LAST_ADDR) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy    = 1'b0;
        SweepEn = 1'b0;
        FlagClr = 1'b0;
        unique case (state)
            IDLE:    FlagClr = Clear;
            SWEEP: begin
                Busy    = 1'b1;
                SweepEn = 1'b1;
            end
            default: ;
        endcase
    end

    assign SweepAddr = cnt;

endmodule

// File: rtl/reg_file.sv
// 8x8 register file with ALU status flags and a hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = reg_file_pkg::DATA_W,
    parameter int unsigned ADDR_W   = reg_file_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = reg_file_pkg::NUM_REGS
) (
    input  logic       clk,
    input  logic       reset_n,
    reg_file_if.slave  bus
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              busy;
    logic              sweep_en;
    logic              flag_clr;
    logic [ADDR_W-1:0] sweep_addr;
    logic              wr_ok;
    logic              flag_ok;
    logic              zero_flag;
    logic              carry_flag;

    clear_sequencer #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .Clear     (bus.Clear),
        .Busy      (busy),
        .SweepEn   (sweep_en),
        .SweepAddr (sweep_addr),
        .FlagClr   (flag_clr)
    );

    // A Clear accepted in IDLE wins over any same-cycle write or flag update.
    assign wr_ok   = bus.WrEn   && !busy && !bus.Clear;
    assign flag_ok = bus.FlagEn && !busy && !bus.Clear;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (sweep_en) begin
            regs[sweep_addr] <= '0;
        end else if (wr_ok) begin
            regs[bus.WrAddr] <= bus.WrData;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (flag_clr) begin
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
        end else if (flag_ok) begin
            zero_flag  <= bus.ZeroIn;
            carry_flag <= bus.CarryIn;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign bus.RdDataA = (wr_ok && (bus.RdAddrA == bus.WrAddr)) ? bus.WrData : regs[bus.RdAddrA];
    assign bus.RdDataB = (wr_ok && (bus.RdAddrB == bus.WrAddr)) ? bus.WrData : regs[bus.RdAddrB];
`else
    assign bus.RdDataA = regs[bus.RdAddrA];
    assign bus.RdDataB = regs[bus.RdAddrB];
`endif

    assign bus.ZeroFlag  = zero_flag;
    assign bus.CarryFlag = carry_flag;
    assign bus.Busy      = busy;

endmodule
